// File: rtl/async_link_arbiter_pkg.sv
// Shared types and constants for the async link arbiter and the link top-level.
package async_link_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int LINK_DATA_W = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    COMPLETE
  } state_t;
endpackage

// File: rtl/async_link_arbiter_rr.sv
// Combinational round-robin search: first set req bit strictly after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic               gnt_valid,
  output logic [SEL_W-1:0]   gnt_idx
);
  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end
endmodule

// File: rtl/async_link_arbiter.sv
// Round-robin scheduler sharing one 4-phase start/ack link among NUM_REQ requesters.
module async_link_arbiter
  import async_link_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = LINK_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        busy,
  output logic                        link_start,
  output logic                        link_rw,
  output logic [DATA_W-1:0]           link_wdata,
  input  logic [DATA_W-1:0]           link_rdata,
  input  logic                        link_ack
);
  localparam int SEL_W = $clog2(NUM_REQ);

  // Handshake: a requester holds req high until it sees its one-cycle done pulse;
  // on the link, link_start stays high until link_ack rises, then ack must fall
  // before the transfer is reported complete.
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               err_flag;
  logic [SEL_W-1:0]   rr_ptr;
  logic               gnt_valid;
  logic [SEL_W-1:0]   gnt_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      link_start <= 1'b0;
      link_rw    <= 1'b0;
      link_wdata <= '0;
      rr_ptr     <= SEL_W'(NUM_REQ - 1);
      cnt        <= '0;
      err_flag   <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt_id     <= gnt_idx;
            link_rw    <= req_rw[gnt_idx];
            link_wdata <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            link_start <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          // An ack arriving on the final counted cycle still wins over the abort.
          if (link_ack) begin
            if (link_rw) rdata <= link_rdata;
            link_start <= 1'b0;
            err_flag   <= 1'b0;
            cnt        <= '0;
            state      <= RELEASE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            link_start <= 1'b0;
            err_flag   <= 1'b1;
            cnt        <= '0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (!link_ack) begin
            done  <= NUM_REQ'(1) << gnt_id;
            err   <= err_flag;
            state <= COMPLETE;
          end
        end
        COMPLETE: begin
          rr_ptr <= gnt_id;
          cnt    <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/async_link_arbiter.md
Name: async_link_arbiter

Overview:
- Round-robin scheduler that shares one master/slave async handshake link (start/rw/data, 4-phase ack) between NUM_REQ local requesters.
- Sits between the requesters and the link top-level. It picks one requester, drives link_start, link_rw and link_wdata, and waits for the 4-phase ack to rise and fall.
- It then returns completion, read data and a timeout error to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 4, link data width
- TIMEOUT, 15, max cycles in ISSUE waiting for link_ack high before abort (1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request level; held high until that requester's done pulse
- req_rw  input  NUM_REQ  per-requester direction: 0 = write master->slave, 1 = read slave->master
- req_wdata  input  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester
- err  output  1  valid with done: 1 = timeout abort
- rdata  output  DATA_W  read data, valid with done for a read; holds its value otherwise
- gnt_id  output  $clog2(NUM_REQ)  index of the current/last granted requester
- busy  output  1  high in every state except IDLE
- link_start  output  1  link start request
- link_rw  output  1  link direction
- link_wdata  output  DATA_W  link write data
- link_rdata  input  DATA_W  link read data, sampled when link_ack rises
- link_ack  input  1  link completion ack, already synchronised to clk

Behaviour:
- Reset (sync, rst=1 at a clk edge) forces:
  - state=IDLE
  - done=0, err=0, rdata=0, gnt_id=0, busy=0
  - link_start=0, link_rw=0, link_wdata=0
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority after reset
  - timeout counter=0
- Reset mid-transaction aborts immediately, with no done pulse.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RELEASE, COMPLETE.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Latch gnt_id, link_rw=req_rw[gnt] and link_wdata=the selected slice; set link_start=1; go to ISSUE.
  - Request-to-link_start latency is 1 cycle.
- ISSUE:
  - Hold link_start=1 and keep rw/wdata stable. The counter increments every cycle.
  - If link_ack=1: if link_rw=1, capture rdata=link_rdata; set link_start=0; go to RELEASE; err_flag=0.
  - Else if counter==TIMEOUT-1: set link_start=0; err_flag=1; go to RELEASE.
  - link_ack=1 in the same cycle as the timeout wins: normal completion.
- RELEASE:
  - Wait for link_ack=0, then go to COMPLETE. No timeout applies in this state.
- COMPLETE:
  - Drive done[gnt_id]=1 and err=err_flag for exactly one cycle.
  - rr_ptr=gnt_id; counter=0; go to IDLE.
- Back-to-back arbitration: the earliest next link_start is 2 cycles after the done pulse, because done is registered and IDLE arbitrates on the following edge. Requesters drop req on seeing done.
- A req deasserted while granted is ignored; the transaction completes and done still pulses.
- req_rw/req_wdata are sampled only at grant; later changes are ignored.
- A link_ack already high in IDLE is ignored. ISSUE requires link_ack high, and a stale high ack completes immediately, which is legal link behaviour.
- The timeout counter is 8 bits; it never wraps because it is cleared on leaving ISSUE.
- Write transactions leave rdata unchanged.

Decomposition:
- Package async_link_pkg holds:
  - state enum {IDLE, ISSUE, RELEASE, COMPLETE}
  - localparams ID_W=$clog2(NUM_REQ) and CNT_W=8
  - DATA_W default constant, shared with the link top
- Sub-module rr_arbiter (combinational priority search): inputs req and rr_ptr; outputs gnt_valid and gnt_idx.

Test Plan:
- Single write: req[0]=1, req_rw[0]=0, wdata slice0=4'd12 -> link_start rises 1 cycle later with link_wdata=12, link_rw=0. The link model acks after 3 cycles and drops the ack 2 cycles later -> done[0] pulses once, err=0, rdata unchanged.
- Single read: req[2]=1, req_rw[2]=1. The model returns link_rdata=4'd13 with ack -> done[2] pulses with rdata=13, err=0, gnt_id=2.
- Round-robin: req=4'b1111 held, each requester dropping its req after its done -> grant order 0,1,2,3. Then req=4'b1001 after serving 3 -> grant order 0,3.
- Timeout: req[1]=1 and the model never acks -> link_start high for exactly 15 cycles, then low; done[1] pulses with err=1; the next request is served normally.
- Ack at the timeout boundary: the model asserts ack on the 15th ISSUE cycle -> err=0, and rdata is captured for a read.
- Reset mid-operation: rst=1 during ISSUE -> the next edge shows link_start=0, busy=0, no done pulse, rr_ptr reset so requester 0 is granted first afterwards.
